// File: rtl/npu_act_wr_arbiter.sv
// Round-robin serialiser for the 32 neuron activation write requests onto the
// single activation-memory write port, with a layer drain handshake.
module npu_act_wr_arbiter #(
  parameter int NUM_CH     = 32,
  parameter int DATA_W     = 8,
  parameter int ACT_ADDR_W = 10,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            hw_mem_wr,
  input  logic [NUM_CH*ACT_ADDR_W-1:0] hw_mem_wr_addr,
  input  logic [NUM_CH*DATA_W-1:0]     hw_mem_wr_data,
  output logic [NUM_CH-1:0]            hw_mem_wr_ack_p,
  input  logic                         act_mem_busy,
  output logic                         act_mem_we,
  output logic [ACT_ADDR_W-1:0]        act_mem_addr,
  output logic [DATA_W-1:0]            act_mem_wdata,
  input  logic                         drain_req_p,
  output logic                         drain_done_p,
  input  logic                         clr_cnt_p,
  output logic [CNT_W-1:0]             wr_count,
  output logic                         arb_busy
);

  localparam int IDX_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        rr_ptr;
  logic [NUM_CH-1:0]       eff_req;
  logic                    gnt_vld;
  logic [IDX_W-1:0]        gnt_idx;
  logic [IDX_W-1:0]        cand;
  logic [ACT_ADDR_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]       gnt_data;

  // The neuron acked this cycle still holds its request; mask it to avoid a double grant.
  assign eff_req = hw_mem_wr & ~hw_mem_wr_ack_p;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!act_mem_busy) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cand = rr_ptr + IDX_W'(i);
        if (!gnt_vld && eff_req[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign gnt_addr = hw_mem_wr_addr[int'(gnt_idx)*ACT_ADDR_W +: ACT_ADDR_W];
  assign gnt_data = hw_mem_wr_data[int'(gnt_idx)*DATA_W +: DATA_W];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|hw_mem_wr) state_nxt = ACTIVE;
      ACTIVE:  if (~|hw_mem_wr) state_nxt = IDLE;
      DRAIN:   if (~|eff_req && !gnt_vld) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A drain request re-entering DRAIN would restart nothing useful, so it is ignored there.
    if (drain_req_p && state != DRAIN) state_nxt = DRAIN;
  end

  assign drain_done_p = (state == DONE);
  assign arb_busy     = (state != IDLE) | (|hw_mem_wr);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      act_mem_we      <= 1'b0;
      act_mem_addr    <= '0;
      act_mem_wdata   <= '0;
      hw_mem_wr_ack_p <= '0;
      wr_count        <= '0;
    end else begin
      state           <= state_nxt;
      act_mem_we      <= gnt_vld;
      hw_mem_wr_ack_p <= gnt_vld ? (NUM_CH'(1) << gnt_idx) : '0;
      if (gnt_vld) begin
        act_mem_addr  <= gnt_addr;
        act_mem_wdata <= gnt_data;
        rr_ptr        <= gnt_idx + IDX_W'(1);
      end
      if (clr_cnt_p)
        wr_count <= '0;
      else if (gnt_vld && wr_count != '1)
        wr_count <= wr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_npu_act_wr_arbiter.sv
// Scoreboard bench for npu_act_wr_arbiter: a neuron-level model predicts each
// write and drain completion; a monitor compares them against the DUT.
module tb_npu_act_wr_arbiter;

  localparam int N  = 32;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    hw_mem_wr;
  logic [N*AW-1:0] addr_bus;
  logic [N*DW-1:0] data_bus;
  logic [N-1:0]    ack_p;
  logic            busy;
  logic            we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            drain_req;
  logic            drain_done;
  logic            clr;
  logic [CW-1:0]   wr_count;
  logic            arb_busy;

  npu_act_wr_arbiter #(.NUM_CH(N), .DATA_W(DW), .ACT_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .hw_mem_wr       (hw_mem_wr),
    .hw_mem_wr_addr  (addr_bus),
    .hw_mem_wr_data  (data_bus),
    .hw_mem_wr_ack_p (ack_p),
    .act_mem_busy    (busy),
    .act_mem_we      (we),
    .act_mem_addr    (mem_addr),
    .act_mem_wdata   (mem_wdata),
    .drain_req_p     (drain_req),
    .drain_done_p    (drain_done),
    .clr_cnt_p       (clr),
    .wr_count        (wr_count),
    .arb_busy        (arb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            stamp;
  } wr_t;

  wr_t           sb[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  bit            mon_en = 0;
  logic [AW-1:0] addr_a[N];
  logic [DW-1:0] data_a[N];
  bit            pend[N];
  int            acked_now = -1;
  int            ptr = 0;
  int            exp_cnt = 0;
  bit            drain_flag = 0;
  int            exp_done = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: neurons in new_req raise a request, the model decides the grant.
  task automatic step(input logic [N-1:0] new_req, input bit b, input bit dr,
                      input bit cl, input bit rv);
    int g;
    int idx;
    int next_ack;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (new_req[i] && !pend[i] && acked_now != i) pend[i] = 1'b1;
    rst       = rv;
    busy      = b;
    drain_req = dr;
    clr       = cl;
    for (int i = 0; i < N; i++) begin
      hw_mem_wr[i]         = pend[i] || (acked_now == i);
      addr_bus[i*AW +: AW] = addr_a[i];
      data_bus[i*DW +: DW] = data_a[i];
    end
    next_ack = -1;
    if (!rv) begin
      ptr        = 0;
      exp_cnt    = 0;
      drain_flag = 1'b0;
      exp_done   = -1;
    end else begin
      g = -1;
      if (!b)
        for (int j = 0; j < N; j++) begin
          idx = (ptr + j) % N;
          if (g < 0 && pend[idx]) g = idx;
        end
      if (g >= 0) begin
        sb.push_back('{g, addr_a[g], data_a[g], cyc + 1});
        pend[g]  = 1'b0;
        next_ack = g;
        ptr      = (g + 1) % N;
      end
      if (cl) exp_cnt = 0;
      else if (g >= 0 && exp_cnt < (1 << CW) - 1) exp_cnt++;
      if (dr) drain_flag = 1'b1;
      if (drain_flag && !any_pend()) begin
        exp_done   = cyc + 2;
        drain_flag = 1'b0;
      end
    end
    @(posedge clk);
    acked_now = next_ack;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].stamp < cyc) begin
        check("missed_write_cycle", 64'(cyc), 64'(sb[0].stamp));
        void'(sb.pop_front());
      end
      if (we || ack_p != '0) begin
        if (sb.size() == 0) begin
          check("spurious_write", {we, ack_p}, '0);
        end else begin
          e = sb.pop_front();
          check("ack_p", ack_p, 64'(1) << e.idx);
          check("we", we, 1);
          check("addr", mem_addr, e.a);
          check("wdata", mem_wdata, e.d);
          check("write_cycle", 64'(cyc), 64'(e.stamp));
        end
      end
      check("wr_count", wr_count, exp_cnt);
      check("drain_done_p", drain_done, cyc == exp_done);
      if (|hw_mem_wr) check("arb_busy_req", arb_busy, 1);
    end
  end

  initial begin
    logic [N-1:0] nr;
    rst = 1'b0; busy = 1'b0; drain_req = 1'b0; clr = 1'b0;
    hw_mem_wr = '0; addr_bus = '0; data_bus = '0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = AW'($urandom);
      data_a[i] = DW'($urandom);
      pend[i]   = 1'b0;
    end

    do_reset();
    mon_en = 1'b1;
    #2;
    check("rst_we", we, 0);
    check("rst_ack", ack_p, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_done", drain_done, 0);
    check("rst_cnt", wr_count, 0);
    check("rst_arb_busy", arb_busy, 0);

    // Single request on neuron 5.
    addr_a[5] = 10'h012;
    data_a[5] = 8'h7F;
    step(N'(1) << 5, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    check("single_we", we, 1);
    check("single_addr", mem_addr, 10'h012);
    check("single_wdata", mem_wdata, 8'h7F);
    check("single_ack", ack_p, 32'h0000_0020);
    idle(3);
    #2;
    check("single_cnt", wr_count, 1);

    // All 32 from reset.
    do_reset();
    step('1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(33);
    #2;
    check("all32_cnt", wr_count, 32);
    check("all32_idle_busy", arb_busy, 0);

    // Round robin from rr_ptr=30 over neurons 2, 30, 31.
    do_reset();
    step(N'(1) << 29, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    step((N'(1) << 2) | (N'(1) << 30) | (N'(1) << 31), 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);

    // Memory busy for 3 cycles with 4 requests pending.
    nr = (N'(1) << 3) | (N'(1) << 9) | (N'(1) << 17) | (N'(1) << 25);
    step(nr, 1'b1, 1'b0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(6);

    // Drain with 3 pending, then drain with none pending.
    nr = (N'(1) << 1) | (N'(1) << 12) | (N'(1) << 28);
    step(nr, 1'b1, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(6);
    step('0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(4);

    // Clear coincident with a grant wins.
    step((N'(1) << 7) | (N'(1) << 8), 1'b0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    #2;
    check("clr_priority_cnt", wr_count, 0);
    idle(2);

    // Reset during the 10th cycle of a 32-write burst.
    do_reset();
    step('1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("midrst_we", we, 0);
    check("midrst_ack", ack_p, 0);
    check("midrst_addr", mem_addr, 0);
    check("midrst_wdata", mem_wdata, 0);
    check("midrst_cnt", wr_count, 0);
    idle(40);

    // Randomised traffic with memory busy and counter clears.
    for (int k = 0; k < 400; k++) begin
      nr = '0;
      for (int i = 0; i < N; i++)
        if (!pend[i] && acked_now != i && $urandom_range(0, 3) == 0) begin
          nr[i]     = 1'b1;
          addr_a[i] = AW'($urandom);
          data_a[i] = DW'($urandom);
        end
      step(nr, $urandom_range(0, 3) == 0, 1'b0, $urandom_range(0, 31) == 0, 1'b1);
    end

    // Final drain flushes everything still pending; bounded wait.
    step('0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 80 && (any_pend() || cyc <= exp_done || exp_done < 0); k++)
      idle(1);
    idle(2);
    check("sb_empty", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
